// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: cause codes, CSR bit indices, FSM states and arbitration for trap_ctrl
package trap_ctrl_pkg;
  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam int MIE_MEI = 11;
  localparam int MIE_MTI = 7;
  localparam int MIE_MSI = 3;
  localparam int IRQ_MEI = 2;
  localparam int IRQ_MTI = 1;
  localparam int IRQ_MSI = 0;
  typedef enum logic [1:0] {S_IDLE, S_TAKE, S_REDIR} state_t;
  typedef struct packed {
    logic [3:0] code;
    logic       intr;
    logic [2:0] hot;
  } trap_t;
  // Exception beats every interrupt; among interrupts MEI > MSI > MTI.
  function automatic trap_t arbitrate(input logic exc, input logic [3:0] exc_code, input logic [2:0] pend);
    return exc ? trap_t'{exc_code, 1'b0, 3'b000} :
           pend[IRQ_MEI] ? trap_t'{CAUSE_MEI, 1'b1, 3'b100} :
           pend[IRQ_MSI] ? trap_t'{CAUSE_MSI, 1'b1, 3'b001} :
                           trap_t'{CAUSE_MTI, 1'b1, 3'b010};
  endfunction
endpackage

// File: rtl/trap_ctrl_int_sync.sv
// int_sync: STAGES-deep synchroniser for one asynchronous level input
module int_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;
  always_ff @(posedge clk)
    if (rst) chain <= '0;
    else chain <= STAGES'({chain, d});
  assign q = chain[STAGES-1];
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: interrupt/exception arbiter and trap-entry sequencer in front of WB and CSR
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int REDIR_TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        int_meip_i,
  input  logic        int_mtip_i,
  input  logic        int_msip_i,
  input  logic        mstatus_mie_i,
  input  logic [31:0] mie_i,
  input  logic        wb_valid_i,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_code_i,
  input  logic        redirect_ack_i,
  output logic        kill_wb_o,
  output logic        is_trap_o,
  output logic [3:0]  trap_code_o,
  output logic        is_interrupt_o,
  output logic        int_meip_o,
  output logic        int_mtip_o,
  output logic        int_msip_o,
  output logic        stall_o,
  output logic        err_o
);
  state_t state, state_nx;
  trap_t trap;
  logic [3:0] cnt;
  logic mask, err, take, timeout;
  logic [2:0] raw, sync, pend;
  logic unused_mie;
  assign raw = {int_meip_i, int_mtip_i, int_msip_i};
  assign unused_mie = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};
  for (genvar i = 0; i < 3; i++) begin : g_sync
    int_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk_i), .rst(rst_i), .d(raw[i]), .q(sync[i]));
  end
  assign pend = sync & {mie_i[MIE_MEI], mie_i[MIE_MTI], mie_i[MIE_MSI]} & {3{mstatus_mie_i & ~mask}};
  always_comb begin
    take = state == S_IDLE && (exc_valid_i || (wb_valid_i && |pend));
    timeout = state == S_REDIR && !redirect_ack_i && cnt == 4'(REDIR_TIMEOUT);
    state_nx = take ? S_TAKE :
               state == S_TAKE ? S_REDIR :
               (state == S_REDIR && (redirect_ack_i || timeout)) ? S_IDLE : state;
    kill_wb_o = take;
    is_trap_o = state == S_TAKE;
    stall_o = state != S_IDLE;
    trap_code_o = is_trap_o ? trap.code : 4'd0;
    is_interrupt_o = is_trap_o & trap.intr;
    {int_meip_o, int_mtip_o, int_msip_o} = is_trap_o ? trap.hot : 3'b000;
    err_o = err;
  end
  // cnt holds 1 on entry to S_REDIR so it equals the number of cycles spent there
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= S_IDLE;
      trap <= '0;
      cnt <= 4'd1;
      mask <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) trap <= arbitrate(exc_valid_i, exc_code_i, pend);
      cnt <= state == S_REDIR ? cnt + 4'd1 : 4'd1;
      mask <= (state == S_REDIR && redirect_ack_i) ? 1'b1 :
              (state == S_IDLE && wb_valid_i && !exc_valid_i) ? 1'b0 : mask;
      err <= err | timeout | (state != S_IDLE && exc_valid_i);
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed scenario tests for trap_ctrl with hand-computed expectations
module tb_trap_ctrl;
  logic clk = 1'b0;
  logic rst_i, int_meip_i, int_mtip_i, int_msip_i, mstatus_mie_i;
  logic [31:0] mie_i;
  logic wb_valid_i, exc_valid_i, redirect_ack_i;
  logic [3:0] exc_code_i;
  logic kill_wb_o, is_trap_o, is_interrupt_o, int_meip_o, int_mtip_o, int_msip_o, stall_o, err_o;
  logic [3:0] trap_code_o;
  logic [11:0] obs;
  int n_checks = 0;
  int n_fail = 0;

  trap_ctrl #(.SYNC_STAGES(2), .REDIR_TIMEOUT(15)) dut (
    .clk_i(clk), .rst_i(rst_i), .int_meip_i(int_meip_i), .int_mtip_i(int_mtip_i),
    .int_msip_i(int_msip_i), .mstatus_mie_i(mstatus_mie_i), .mie_i(mie_i),
    .wb_valid_i(wb_valid_i), .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i),
    .redirect_ack_i(redirect_ack_i), .kill_wb_o(kill_wb_o), .is_trap_o(is_trap_o),
    .trap_code_o(trap_code_o), .is_interrupt_o(is_interrupt_o), .int_meip_o(int_meip_o),
    .int_mtip_o(int_mtip_o), .int_msip_o(int_msip_o), .stall_o(stall_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  // obs layout: kill, trap, code[3:0], intr, {meip,mtip,msip}, stall, err
  assign obs = {kill_wb_o, is_trap_o, trap_code_o, is_interrupt_o, int_meip_o, int_mtip_o, int_msip_o, stall_o, err_o};

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    {int_meip_i, int_mtip_i, int_msip_i, mstatus_mie_i, wb_valid_i, exc_valid_i, redirect_ack_i} = '0;
    mie_i = '0;
    exc_code_i = '0;
    cyc();
    cyc();
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    {int_meip_i, int_mtip_i, int_msip_i, mstatus_mie_i, wb_valid_i} = '1;
    mie_i = '1;
    exc_valid_i = 1'b0;
    redirect_ack_i = 1'b0;
    exc_code_i = 4'd0;
    cyc();
    cyc();
    #1;
    n_checks++;
    if (obs !== 12'b0) begin n_fail++; $display("FAIL reset_state: obs=%b exp=%b", obs, 12'b0); end
    do_reset();
  endtask

  task automatic test_mti;
    mstatus_mie_i = 1'b1;
    mie_i = 32'h80;
    wb_valid_i = 1'b1;
    int_mtip_i = 1'b1;
    #1;
    n_checks++;
    if (obs !== 12'b0) begin n_fail++; $display("FAIL mti_sync0: obs=%b exp=%b", obs, 12'b0); end
    cyc(); #1;
    n_checks++;
    if (obs !== 12'b0) begin n_fail++; $display("FAIL mti_sync1: obs=%b exp=%b", obs, 12'b0); end
    cyc(); #1;
    n_checks++;
    if (obs !== 12'b1_0_0000_0_000_0_0) begin n_fail++; $display("FAIL mti_kill: obs=%b exp=%b", obs, 12'b1_0_0000_0_000_0_0); end
    cyc(); #1;
    n_checks++;
    if (obs !== 12'b0_1_0111_1_010_1_0) begin n_fail++; $display("FAIL mti_take: obs=%b exp=%b", obs, 12'b0_1_0111_1_010_1_0); end
    cyc(); #1;
    n_checks++;
    if (obs !== 12'b0_0_0000_0_000_1_0) begin n_fail++; $display("FAIL mti_redir: obs=%b exp=%b", obs, 12'b0_0_0000_0_000_1_0); end
    redirect_ack_i = 1'b1;
    cyc();
    redirect_ack_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 12'b0) begin n_fail++; $display("FAIL mti_masked: obs=%b exp=%b", obs, 12'b0); end
    cyc(); #1;
    n_checks++;
    if (obs !== 12'b1_0_0000_0_000_0_0) begin n_fail++; $display("FAIL mti_unmasked: obs=%b exp=%b", obs, 12'b1_0_0000_0_000_0_0); end
    do_reset();
  endtask

  task automatic test_exc_vs_int;
    mstatus_mie_i = 1'b1;
    mie_i = 32'h800;
    int_meip_i = 1'b1;
    cyc();
    cyc();
    wb_valid_i = 1'b1;
    exc_valid_i = 1'b1;
    exc_code_i = 4'd2;
    #1;
    n_checks++;
    if (obs !== 12'b1_0_0000_0_000_0_0) begin n_fail++; $display("FAIL exc_kill: obs=%b exp=%b", obs, 12'b1_0_0000_0_000_0_0); end
    cyc();
    exc_valid_i = 1'b0;
    wb_valid_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 12'b0_1_0010_0_000_1_0) begin n_fail++; $display("FAIL exc_take: obs=%b exp=%b", obs, 12'b0_1_0010_0_000_1_0); end
    cyc();
    redirect_ack_i = 1'b1;
    cyc();
    redirect_ack_i = 1'b0;
    wb_valid_i = 1'b1;
    #1;
    n_checks++;
    if (obs !== 12'b0) begin n_fail++; $display("FAIL exc_handler_retire: obs=%b exp=%b", obs, 12'b0); end
    cyc(); #1;
    n_checks++;
    if (kill_wb_o !== 1'b1) begin n_fail++; $display("FAIL exc_then_mei_kill: got %b want 1", kill_wb_o); end
    cyc();
    wb_valid_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 12'b0_1_1011_1_100_1_0) begin n_fail++; $display("FAIL exc_then_mei_take: obs=%b exp=%b", obs, 12'b0_1_1011_1_100_1_0); end
    do_reset();
  endtask

  task automatic test_priority;
    mstatus_mie_i = 1'b1;
    mie_i = 32'h888;
    {int_meip_i, int_mtip_i, int_msip_i} = 3'b111;
    wb_valid_i = 1'b1;
    cyc();
    cyc();
    cyc();
    int_meip_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 12'b0_1_1011_1_100_1_0) begin n_fail++; $display("FAIL prio_mei: obs=%b exp=%b", obs, 12'b0_1_1011_1_100_1_0); end
    cyc();
    redirect_ack_i = 1'b1;
    cyc();
    redirect_ack_i = 1'b0;
    cyc();
    cyc(); #1;
    n_checks++;
    if (obs !== 12'b0_1_0011_1_001_1_0) begin n_fail++; $display("FAIL prio_msi: obs=%b exp=%b", obs, 12'b0_1_0011_1_001_1_0); end
    do_reset();
  endtask

  task automatic test_masked;
    bit seen;
    int_mtip_i = 1'b1;
    wb_valid_i = 1'b1;
    mie_i = 32'h80;
    mstatus_mie_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin cyc(); #1; if (kill_wb_o | is_trap_o) seen = 1'b1; end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL mask_mstatus: trap seen=%b want 0", seen); end
    mstatus_mie_i = 1'b1;
    mie_i = ~32'h80;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin cyc(); #1; if (kill_wb_o | is_trap_o) seen = 1'b1; end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL mask_mie7: trap seen=%b want 0", seen); end
    mie_i = 32'h80;
    #1;
    n_checks++;
    if (kill_wb_o !== 1'b1) begin n_fail++; $display("FAIL mask_released: kill got %b want 1", kill_wb_o); end
    do_reset();
  endtask

  task automatic test_timeout;
    int n;
    mstatus_mie_i = 1'b1;
    mie_i = 32'h80;
    int_mtip_i = 1'b1;
    wb_valid_i = 1'b1;
    cyc();
    cyc();
    cyc();
    wb_valid_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 12'b0_1_0111_1_010_1_0) begin n_fail++; $display("FAIL tmo_take: obs=%b exp=%b", obs, 12'b0_1_0111_1_010_1_0); end
    n = 0;
    for (int i = 0; i < 40; i++) begin cyc(); #1; if (!stall_o) break; n++; end
    n_checks++;
    if (n != 15) begin n_fail++; $display("FAIL tmo_stall_cycles: got %0d want 15", n); end
    n_checks++;
    if (obs !== 12'b0_0_0000_0_000_0_1) begin n_fail++; $display("FAIL tmo_exit: obs=%b exp=%b", obs, 12'b0_0_0000_0_000_0_1); end
    for (int i = 0; i < 5; i++) cyc();
    #1;
    n_checks++;
    if (err_o !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: err got %b want 1", err_o); end
    do_reset();
  endtask

  task automatic test_reset_mid_trap;
    mstatus_mie_i = 1'b1;
    mie_i = 32'h80;
    int_mtip_i = 1'b1;
    wb_valid_i = 1'b1;
    cyc();
    cyc();
    cyc();
    wb_valid_i = 1'b0;
    exc_valid_i = 1'b1;
    exc_code_i = 4'd5;
    cyc();
    exc_valid_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 12'b0_0_0000_0_000_1_1) begin n_fail++; $display("FAIL busy_exc_err: obs=%b exp=%b", obs, 12'b0_0_0000_0_000_1_1); end
    rst_i = 1'b1;
    cyc();
    #1;
    n_checks++;
    if (obs !== 12'b0) begin n_fail++; $display("FAIL rst_mid_trap: obs=%b exp=%b", obs, 12'b0); end
    rst_i = 1'b0;
    wb_valid_i = 1'b1;
    #1;
    n_checks++;
    if (obs !== 12'b0) begin n_fail++; $display("FAIL rst_sync_cleared: obs=%b exp=%b", obs, 12'b0); end
    do_reset();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    do_reset();
    test_reset();
    test_mti();
    test_exc_vs_int();
    test_priority();
    test_masked();
    test_timeout();
    test_reset_mid_trap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
